// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
//   DEF_DATA_WIDTH : default FIFO word / stream data width
//   DEF_CNT_WIDTH  : default width of the delivered-word counter
//   data_t, cnt_t  : word and counter types at the default widths
//   occ_t          : buffer occupancy, 0..2 words
package fifo_stream_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;
    typedef logic [DEF_CNT_WIDTH-1:0]  cnt_t;
    typedef logic [1:0]                occ_t;
endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle between the FIFO read port, the adapter and the stream consumer.
//   fifo_empty / fifo_r_en / fifo_rdata : FIFO read port (r_en -> data next cycle)
//   m_valid / m_ready / m_data          : downstream valid/ready stream
// Modports:
//   master : the adapter (drives r_en and the stream outputs)
//   slave  : the environment (FIFO and consumer)
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = fifo_stream_pkg::DEF_DATA_WIDTH
);
    logic                  fifo_empty;
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_r_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_r_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_stream_adapter_stream_buf2.sv
// Two-entry in-order word buffer.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write push_data into the tail entry this cycle
//   push_data  : word to store
//   pop        : retire the head word this cycle
//   occ        : number of stored words (0..2)
//   head_data  : oldest stored word
module stream_buf2
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [DATA_WIDTH-1:0] entry [2];
    logic                  head;
    logic                  tail;

    // Tail sits occ slots past the head, modulo 2. With occ=2 a push is only
    // legal alongside a pop, so writing over the retiring head is safe.
    assign tail      = head ^ occ[0];
    assign head_data = entry[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            head     <= 1'b0;
            occ      <= '0;
        end else begin
            if (push) entry[tail] <= push_data;
            if (pop)  head        <= ~head;
            occ <= occ + occ_t'(push) - occ_t'(pop);
        end
    end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drain stage for the synchronous FIFO: issues reads, absorbs the one-cycle
// read latency in a two-entry buffer and presents words on a valid/ready
// stream at full throughput, counting delivered words.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : FIFO read port + output stream (master side)
//   xfer_cnt   : completed transfers, wraps modulo 2^CNT_WIDTH
module fifo_rd_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fifo_rd_stream_adapter_if.master bus,
    output logic [CNT_WIDTH-1:0]     xfer_cnt
);
    occ_t                  occ;
    logic                  inflight;
    logic                  pop;
    logic [2:0]            level;
    logic [DATA_WIDTH-1:0] head_data;

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head_data;
    assign pop         = bus.m_valid & bus.m_ready;

    // Words that will be held next cycle if nothing new is read; a read is
    // only issued when its returning word is guaranteed a free slot.
    assign level         = 3'(occ) + 3'(inflight) - 3'(pop);
    assign bus.fifo_r_en = rst_n & ~bus.fifo_empty & (level <= 3'd1);

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (bus.fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            inflight <= bus.fifo_r_en;
            if (pop) xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: a depth-8 synchronous FIFO model feeds the adapter; an
// ordering scoreboard watches every stream transfer.
module tb_fifo_rd_stream_adapter;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          m_ready = 1'b0;
    logic [CW-1:0] xfer_cnt;

    int tests = 0;
    int fails = 0;
    int empty_reads = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .xfer_cnt (xfer_cnt)
    );

    // Synchronous FIFO model, depth 8, registered data_out.
    logic [DW-1:0] mem [8];
    logic [2:0]    wp, rp;
    logic [3:0]    fcnt;
    logic [DW-1:0] f_dout;
    logic          f_wr, f_rd;

    assign f_wr = w_en && (fcnt < 4'd8);
    assign f_rd = bus.fifo_r_en && (fcnt != 4'd0);

    always @(posedge clk) begin
        if (!fifo_rst_n) begin
            wp <= '0; rp <= '0; fcnt <= '0; f_dout <= '0;
        end else begin
            if (f_wr) begin mem[wp] <= w_data; wp <= wp + 3'd1; end
            if (f_rd) begin f_dout <= mem[rp]; rp <= rp + 3'd1; end
            fcnt <= fcnt + 4'(f_wr) - 4'(f_rd);
        end
    end

    assign bus.fifo_empty = (fcnt == 4'd0);
    assign bus.fifo_rdata = f_dout;
    assign bus.m_ready    = m_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sampled mid-cycle, so a transfer seen here completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.fifo_r_en && bus.fifo_empty) empty_reads++;
        if (rst_n && bus.m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.m_data), 32'hFFFF_FFFF);
            end else begin
                check("order", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [DW-1:0] d);
        w_en   = 1'b1;
        w_data = d;
        exp_q.push_back(d);
    endtask

    task automatic reset_all();
        rst_n = 1'b0; fifo_rst_n = 1'b0; w_en = 1'b0; m_ready = 1'b0;
        cyc(); cyc();
        exp_q.delete();
        rst_n = 1'b1; fifo_rst_n = 1'b1;
    endtask

    initial begin
        int first, last, nv, rcnt, sent;

        // 1: adapter held in reset while the FIFO holds words
        rst_n = 1'b0; fifo_rst_n = 1'b0;
        cyc();
        fifo_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_en = 1'b1; w_data = 8'(8'h30 + i);
            cyc();
        end
        w_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_fifo_loaded", 32'(bus.fifo_empty), 32'd0);
            check("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
            check("rst_m_valid", 32'(bus.m_valid), 32'd0);
            check("rst_m_data", 32'(bus.m_data), 32'd0);
            check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
            cyc();
        end
        reset_all();

        // 2: single-word latency
        m_ready = 1'b1;
        put(8'hA5);
        cyc();
        w_en = 1'b0;
        #1;
        check("lat_r_en", 32'(bus.fifo_r_en), 32'd1);
        check("lat_valid0", 32'(bus.m_valid), 32'd0);
        cyc(); #1;
        check("lat_r_en_off", 32'(bus.fifo_r_en), 32'd0);
        check("lat_valid1", 32'(bus.m_valid), 32'd0);
        cyc(); #1;
        check("lat_valid2", 32'(bus.m_valid), 32'd1);
        check("lat_data", 32'(bus.m_data), 32'hA5);
        check("lat_cnt_before", 32'(xfer_cnt), 32'd0);
        cyc(); #1;
        check("lat_cnt", 32'(xfer_cnt), 32'd1);
        check("lat_valid_done", 32'(bus.m_valid), 32'd0);

        // 3: streaming, eight back-to-back words
        reset_all();
        m_ready = 1'b1;
        first = -1; last = -1; nv = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 8) put(8'(i + 1)); else w_en = 1'b0;
            #1;
            if (bus.m_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
            cyc();
        end
        check("stream_nvalid", 32'(nv), 32'd8);
        check("stream_contig", 32'(last - first), 32'd7);
        check("stream_cnt", 32'(xfer_cnt), 32'd8);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // 4: back-pressure
        reset_all();
        m_ready = 1'b0;
        rcnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 8) put(8'(8'h11 + i)); else w_en = 1'b0;
            #1;
            if (bus.fifo_r_en) rcnt++;
            if (i == 12) check("bp_head_a", 32'(bus.m_data), 32'h11);
            cyc();
        end
        #1;
        check("bp_r_en_pulses", 32'(rcnt), 32'd2);
        check("bp_fifo_left", 32'(fcnt), 32'd6);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_head_b", 32'(bus.m_data), 32'h11);
        check("bp_r_en_idle", 32'(bus.fifo_r_en), 32'd0);
        cyc();
        m_ready = 1'b1;
        first = -1; last = -1; nv = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.m_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
            cyc();
        end
        check("bp_nvalid", 32'(nv), 32'd8);
        check("bp_first", 32'(first), 32'd0);
        check("bp_contig", 32'(last - first), 32'd7);
        check("bp_cnt", 32'(xfer_cnt), 32'd8);

        // 5: random ready, 200 random words
        reset_all();
        empty_reads = 0;
        sent = 0;
        for (int c = 0; c < 5000 && (sent < 200 || exp_q.size() != 0); c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 200 && fcnt < 4'd8) begin
                put(8'($urandom));
                sent++;
            end else begin
                w_en = 1'b0;
            end
            cyc();
        end
        w_en = 1'b0;
        m_ready = 1'b0;
        cyc(); #1;
        check("rand_sent", 32'(sent), 32'd200);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_empty_reads", 32'(empty_reads), 32'd0);
        check("rand_cnt", 32'(xfer_cnt), 32'd8);

        // 6: counter wrap, then reset with a full buffer
        reset_all();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            put(8'(8'h40 + i));
            cyc();
        end
        w_en = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        #1;
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_cnt", 32'(xfer_cnt), 32'd1);
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; w_data = 8'(8'h70 + i);
            cyc();
        end
        w_en = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        #1;
        check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        check("pre_rst_head", 32'(bus.m_data), 32'h70);
        cyc();
        rst_n = 1'b0; fifo_rst_n = 1'b0;
        #1;
        check("rst_cycle_r_en", 32'(bus.fifo_r_en), 32'd0);
        cyc(); #1;
        check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
        check("mid_rst_data", 32'(bus.m_data), 32'd0);
        rst_n = 1'b1; fifo_rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
